// File: rtl/cu_pkg.sv
// Shared types and constants for the cu_seq control unit: FSM states,
// opcode map, ALU control codes and decode result types.
package cu_pkg;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_WAIT_IR, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_JMP, CLS_JZ, CLS_HALT
  } cls_t;

  typedef struct packed {
    logic a_op;
    logic a_out;
    logic b_op;
    logic b_out;
  } en_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_SHL1  = 4'h4;
  localparam logic [3:0] OP_SHL2  = 4'h5;
  localparam logic [3:0] OP_SHR4  = 4'h6;
  localparam logic [3:0] OP_INC   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SHL1 = 4'b0011;
  localparam logic [3:0] ALU_SHL2 = 4'b0100;
  localparam logic [3:0] ALU_SHR4 = 4'b0101;
  localparam logic [3:0] ALU_INC  = 4'b0110;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decode: operand enables, ALU code, class, illegal flag.
// Opcode B decodes as JZ only when CU_BRANCH_EN is defined, otherwise illegal.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_LEN = 4,
  parameter int ALU_CTRL_W = 4
) (
  input  logic [OPCODE_LEN-1:0] opcode,
  output en_t                   en,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output cls_t                  cls,
  output logic                  illegal
);

  localparam en_t EN_A  = '{a_op: 1'b1, a_out: 1'b1, b_op: 1'b0, b_out: 1'b0};
  localparam en_t EN_AB = '{a_op: 1'b1, a_out: 1'b1, b_op: 1'b1, b_out: 1'b1};
  localparam en_t EN_ST = '{a_op: 1'b1, a_out: 1'b1, b_op: 1'b0, b_out: 1'b1};

  always_comb begin
    en       = '0;
    alu_ctrl = '0;
    cls      = CLS_NOP;
    illegal  = 1'b0;
    case (opcode)
      OPCODE_LEN'(OP_NOP):   cls = CLS_NOP;
      OPCODE_LEN'(OP_MOV):   begin en = EN_A;  alu_ctrl = ALU_CTRL_W'(ALU_PASS); cls = CLS_ALU; end
      OPCODE_LEN'(OP_ADD):   begin en = EN_AB; alu_ctrl = ALU_CTRL_W'(ALU_ADD);  cls = CLS_ALU; end
      OPCODE_LEN'(OP_SUB):   begin en = EN_AB; alu_ctrl = ALU_CTRL_W'(ALU_SUB);  cls = CLS_ALU; end
      OPCODE_LEN'(OP_SHL1):  begin en = EN_A;  alu_ctrl = ALU_CTRL_W'(ALU_SHL1); cls = CLS_ALU; end
      OPCODE_LEN'(OP_SHL2):  begin en = EN_A;  alu_ctrl = ALU_CTRL_W'(ALU_SHL2); cls = CLS_ALU; end
      OPCODE_LEN'(OP_SHR4):  begin en = EN_A;  alu_ctrl = ALU_CTRL_W'(ALU_SHR4); cls = CLS_ALU; end
      OPCODE_LEN'(OP_INC):   begin en = EN_A;  alu_ctrl = ALU_CTRL_W'(ALU_INC);  cls = CLS_ALU; end
      OPCODE_LEN'(OP_LOAD):  begin en = EN_A;  alu_ctrl = ALU_CTRL_W'(ALU_PASS); cls = CLS_LOAD; end
      OPCODE_LEN'(OP_STORE): begin en = EN_ST; alu_ctrl = ALU_CTRL_W'(ALU_PASS); cls = CLS_STORE; end
      OPCODE_LEN'(OP_JMP):   cls = CLS_JMP;
`ifdef CU_BRANCH_EN
      OPCODE_LEN'(OP_JZ):    cls = CLS_JZ;
`else
      OPCODE_LEN'(OP_JZ):    illegal = 1'b1;
`endif
      OPCODE_LEN'(OP_HALT):  cls = CLS_HALT;
      default:               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle control unit for the 16-bit datapath; branch support via CU_BRANCH_EN.
// state   | meaning
// RST     | datapath reset asserted, entered on rst_n
// FETCH   | imem_read strobe
// WAIT_IR | instruction memory latency, ir becomes valid
// DECODE  | opcode/fields latched, pc_inc strobe
// EXEC    | operand enables, ALU code, jump/illegal
// MEM     | data memory strobe held until mem_ready
// WB      | destination register write enables
// HALT    | sticky stop, left only through rst_n
module cu_seq
  import cu_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int OPCODE_LEN = 4,
  parameter int ADDR_AW    = 4,
  parameter int ADDR_BW    = 4,
  parameter int DESTW      = 4,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_WIDTH-1:0]  ir,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  reset,
  output logic [ADDR_AW-1:0]    sel_a,
  output logic [ADDR_BW-1:0]    sel_b,
  output logic [DESTW-1:0]      sel_dest,
  output logic                  en_decAop,
  output logic                  en_decBop,
  output logic                  en_decCop,
  output logic                  en_decAout,
  output logic                  en_decBout,
  output logic                  en_decCout,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  imem_read,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic                  pc_inc,
  output logic                  jump,
  output logic                  illegal,
  output logic                  halted
);

  localparam int A_LSB = BUS_WIDTH - OPCODE_LEN - ADDR_AW;
  localparam int B_LSB = A_LSB - ADDR_BW;
  localparam int D_LSB = B_LSB - DESTW;

  state_t                  state;
  logic [OPCODE_LEN-1:0]   op_q;
  en_t                     dec_en;
  logic [ALU_CTRL_W-1:0]   dec_alu;
  cls_t                    dec_cls;
  logic                    dec_illegal;

  cu_decode #(.OPCODE_LEN(OPCODE_LEN), .ALU_CTRL_W(ALU_CTRL_W)) u_decode (
    .opcode   (op_q),
    .en       (dec_en),
    .alu_ctrl (dec_alu),
    .cls      (dec_cls),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RST;
      op_q       <= '0;
      reset      <= 1'b1;
      sel_a      <= '0;
      sel_b      <= '0;
      sel_dest   <= '0;
      en_decAop  <= 1'b0;
      en_decBop  <= 1'b0;
      en_decCop  <= 1'b0;
      en_decAout <= 1'b0;
      en_decBout <= 1'b0;
      en_decCout <= 1'b0;
      alu_ctrl   <= '0;
      imem_read  <= 1'b0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      pc_inc     <= 1'b0;
      jump       <= 1'b0;
      illegal    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      // Outputs belong to the next state; everything not set below drops.
      reset      <= 1'b0;
      en_decAop  <= 1'b0;
      en_decBop  <= 1'b0;
      en_decCop  <= 1'b0;
      en_decAout <= 1'b0;
      en_decBout <= 1'b0;
      en_decCout <= 1'b0;
      alu_ctrl   <= '0;
      imem_read  <= 1'b0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      pc_inc     <= 1'b0;
      jump       <= 1'b0;
      illegal    <= 1'b0;
      halted     <= 1'b0;
      case (state)
        S_RST: begin
          state     <= S_FETCH;
          imem_read <= 1'b1;
        end
        S_FETCH: state <= S_WAIT_IR;
        S_WAIT_IR: begin
          state    <= S_DECODE;
          op_q     <= ir[BUS_WIDTH-1 -: OPCODE_LEN];
          sel_a    <= ir[A_LSB +: ADDR_AW];
          sel_b    <= ir[B_LSB +: ADDR_BW];
          sel_dest <= ir[D_LSB +: DESTW];
          pc_inc   <= 1'b1;
        end
        S_DECODE: begin
          state      <= S_EXEC;
          en_decAop  <= dec_en.a_op;
          en_decAout <= dec_en.a_out;
          en_decBop  <= dec_en.b_op;
          en_decBout <= dec_en.b_out;
          alu_ctrl   <= dec_alu;
          illegal    <= dec_illegal;
          jump       <= (dec_cls == CLS_JMP) || ((dec_cls == CLS_JZ) && zero);
        end
        S_EXEC: begin
          case (dec_cls)
            CLS_ALU: begin
              state      <= S_WB;
              en_decCop  <= 1'b1;
              en_decCout <= 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              state      <= S_MEM;
              dmem_read  <= (dec_cls == CLS_LOAD);
              dmem_write <= (dec_cls == CLS_STORE);
              en_decAop  <= en_decAop;
              en_decAout <= en_decAout;
              alu_ctrl   <= alu_ctrl;
            end
            CLS_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: begin
              state     <= S_FETCH;
              imem_read <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (dec_cls == CLS_LOAD) begin
              state      <= S_WB;
              en_decCop  <= 1'b1;
              en_decCout <= 1'b1;
            end else begin
              state     <= S_FETCH;
              imem_read <= 1'b1;
            end
          end else begin
            dmem_read  <= dmem_read;
            dmem_write <= dmem_write;
            en_decAop  <= en_decAop;
            en_decAout <= en_decAout;
            alu_ctrl   <= alu_ctrl;
          end
        end
        S_WB: begin
          state     <= S_FETCH;
          imem_read <= 1'b1;
        end
        S_HALT: halted <= 1'b1;
        default: begin
          state <= S_RST;
          reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
